// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: exception bit positions in the
// MEM->WB exception vector, LoongArch ecode/esubcode values and the stage FSM
// state type.
package wb_pkg;

    // Bit positions inside ms_exc = {ale, adef, ine, int, brk, sys}
    localparam int unsigned EXC_SYS  = 0;
    localparam int unsigned EXC_BRK  = 1;
    localparam int unsigned EXC_INT  = 2;
    localparam int unsigned EXC_INE  = 3;
    localparam int unsigned EXC_ADEF = 4;
    localparam int unsigned EXC_ALE  = 5;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_NONE = 6'h00;

    localparam logic [8:0] ESUBCODE_NONE = 9'h000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RETIRE,
        ST_SQUASH
    } ws_state_e;

endpackage

// File: rtl/ws_exc_prio_enc.sv
// Exception priority encoder for the writeback stage.
// Ports:
//   exc_i        exception vector {ale, adef, ine, int, brk, sys}
//   exc_any_o    at least one exception bit set
//   ecode_o      ecode of the highest-priority exception (0 when none)
//   esubcode_o   matching esubcode
// Priority, highest first: int, adef, ale, sys, brk, ine.
module ws_exc_prio_enc
    import wb_pkg::*;
(
    input  logic [5:0] exc_i,
    output logic       exc_any_o,
    output logic [5:0] ecode_o,
    output logic [8:0] esubcode_o
);

    always_comb begin
        exc_any_o  = |exc_i;
        ecode_o    = ECODE_NONE;
        esubcode_o = ESUBCODE_NONE;
        if (exc_i[EXC_INT]) begin
            ecode_o = ECODE_INT;
        end else if (exc_i[EXC_ADEF]) begin
            ecode_o = ECODE_ADEF;
        end else if (exc_i[EXC_ALE]) begin
            ecode_o = ECODE_ALE;
        end else if (exc_i[EXC_SYS]) begin
            ecode_o = ECODE_SYS;
        end else if (exc_i[EXC_BRK]) begin
            ecode_o = ECODE_BRK;
        end else if (exc_i[EXC_INE]) begin
            ecode_o = ECODE_INE;
        end
    end

endmodule

// File: rtl/wb_stage_p.sv
// Parametrised LoongArch writeback stage. Latches one MEM->WB beat, optionally
// waits CSR_RD_LAT cycles for CSR read data, then retires it for one cycle:
// regfile write, CSR strobes, exception / ERTN commit pulses and debug trace.
// A committing exception or ERTN opens a squash window that drops the next
// SQUASH_CYCLES accepted beats.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   ms2ws_valid / ws_allowin   MEM->WB handshake
//   ms_*                       fields of the incoming beat
//   csr_rvalue                 CSR read data
//   csr_re/we/num/wmask/wvalue CSR access for the held beat
//   ws_ex, ertn_flush          single-cycle commit pulses
//   ws_ecode, ws_esubcode      exception code of the held beat
//   ws_pc, ws_vaddr            PC and faulting address of the held beat
//   ws_rf_we/waddr/wdata       regfile write port
//   ws_squash                  squash window active
//   debug_wb_*                 retirement trace
module wb_stage_p
    import wb_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int RF_AW         = 5,
    parameter int CSR_RD_LAT    = 0,
    parameter int SQUASH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ms2ws_valid,
    output logic              ws_allowin,
    input  logic [31:0]       ms_pc,
    input  logic [31:0]       ms_vaddr,
    input  logic              ms_rf_we,
    input  logic [RF_AW-1:0]  ms_rf_waddr,
    input  logic [DATA_W-1:0] ms_rf_wdata,
    input  logic              ms_csr_re,
    input  logic              ms_csr_we,
    input  logic [13:0]       ms_csr_num,
    input  logic [DATA_W-1:0] ms_csr_wmask,
    input  logic [DATA_W-1:0] ms_csr_wvalue,
    input  logic [5:0]        ms_exc,
    input  logic              ms_ertn,
    input  logic [DATA_W-1:0] csr_rvalue,
    output logic              csr_re,
    output logic              csr_we,
    output logic [13:0]       csr_num,
    output logic [DATA_W-1:0] csr_wmask,
    output logic [DATA_W-1:0] csr_wvalue,
    output logic              ws_ex,
    output logic              ertn_flush,
    output logic [5:0]        ws_ecode,
    output logic [8:0]        ws_esubcode,
    output logic [31:0]       ws_pc,
    output logic [31:0]       ws_vaddr,
    output logic              ws_rf_we,
    output logic [RF_AW-1:0]  ws_rf_waddr,
    output logic [DATA_W-1:0] ws_rf_wdata,
    output logic              ws_squash,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata
);

    localparam int WAIT_W = (CSR_RD_LAT > 0) ? $clog2(CSR_RD_LAT + 1) : 1;
    localparam int SQ_W   = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((CSR_RD_LAT > 0) ? CSR_RD_LAT - 1 : 0);
    localparam logic [SQ_W-1:0]   SQ_LOAD   = SQ_W'(SQUASH_CYCLES);

    ws_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [SQ_W-1:0]   sq_q, sq_d;
    logic              capture;
    logic              accept;
    logic              flush;
    logic              beat_valid;
    logic              retire;

    // Held beat
    logic [31:0]       pc_q, vaddr_q;
    logic              rf_we_q, csr_re_q, csr_we_q, ertn_q;
    logic [RF_AW-1:0]  rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q, csr_wmask_q, csr_wvalue_q;
    logic [13:0]       csr_num_q;
    logic [5:0]        exc_q;

    logic              exc_any;
    logic [5:0]        ecode;
    logic [8:0]        esubcode;

    ws_exc_prio_enc u_prio (
        .exc_i      (exc_q),
        .exc_any_o  (exc_any),
        .ecode_o    (ecode),
        .esubcode_o (esubcode)
    );

    assign ws_allowin = (state_q != ST_HOLD);
    assign accept     = ms2ws_valid & ws_allowin;
    assign retire     = (state_q == ST_RETIRE);
    assign beat_valid = (state_q == ST_HOLD) | retire;
    assign flush      = retire & (exc_any | ertn_q);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        sq_d    = sq_q;
        capture = 1'b0;
        case (state_q)
            ST_HOLD: begin
                wait_d = wait_q + WAIT_W'(1);
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_RETIRE;
                end
            end
            ST_SQUASH: begin
                if (accept) begin
                    sq_d = sq_q - SQ_W'(1);
                    if (sq_q == SQ_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                if (flush && (SQUASH_CYCLES > 0)) begin
                    // A beat arriving alongside the flushing retire is the
                    // first dropped beat, so the load and first decrement fold.
                    if (accept) begin
                        sq_d    = SQ_LOAD - SQ_W'(1);
                        state_d = (SQUASH_CYCLES == 1) ? ST_IDLE : ST_SQUASH;
                    end else begin
                        sq_d    = SQ_LOAD;
                        state_d = ST_SQUASH;
                    end
                end else if (accept) begin
                    capture = 1'b1;
                    wait_d  = '0;
                    state_d = (ms_csr_re && (CSR_RD_LAT > 0)) ? ST_HOLD : ST_RETIRE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            sq_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            sq_q    <= sq_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= '0;
            vaddr_q      <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            csr_re_q     <= 1'b0;
            csr_we_q     <= 1'b0;
            csr_num_q    <= '0;
            csr_wmask_q  <= '0;
            csr_wvalue_q <= '0;
            exc_q        <= '0;
            ertn_q       <= 1'b0;
        end else if (capture) begin
            pc_q         <= ms_pc;
            vaddr_q      <= ms_vaddr;
            rf_we_q      <= ms_rf_we;
            rf_waddr_q   <= ms_rf_waddr;
            rf_wdata_q   <= ms_rf_wdata;
            csr_re_q     <= ms_csr_re;
            csr_we_q     <= ms_csr_we;
            csr_num_q    <= ms_csr_num;
            csr_wmask_q  <= ms_csr_wmask;
            csr_wvalue_q <= ms_csr_wvalue;
            exc_q        <= ms_exc;
            ertn_q       <= ms_ertn;
        end
    end

    // Data outputs show the held beat only while one is held; strobes and
    // commit pulses additionally require the retire cycle.
    always_comb begin
        ws_squash   = (state_q == ST_SQUASH);
        ws_rf_we    = retire & rf_we_q & ~exc_any & ~ertn_q;
        csr_we      = retire & csr_we_q & ~exc_any;
        ws_ex       = retire & exc_any;
        ertn_flush  = retire & ertn_q & ~exc_any;
        csr_re      = beat_valid & csr_re_q;
        ws_pc       = beat_valid ? pc_q : '0;
        ws_vaddr    = beat_valid ? vaddr_q : '0;
        ws_rf_waddr = beat_valid ? rf_waddr_q : '0;
        ws_rf_wdata = beat_valid ? (csr_re_q ? csr_rvalue : rf_wdata_q) : '0;
        csr_num     = beat_valid ? csr_num_q : '0;
        csr_wmask   = beat_valid ? csr_wmask_q : '0;
        csr_wvalue  = beat_valid ? csr_wvalue_q : '0;
        ws_ecode    = beat_valid ? ecode : '0;
        ws_esubcode = beat_valid ? esubcode : '0;
    end

    assign debug_wb_pc       = ws_pc;
    assign debug_wb_rf_we    = {4{ws_rf_we}};
    assign debug_wb_rf_wdata = ws_rf_wdata;

    if (RF_AW >= 5) begin : g_wnum_trunc
        assign debug_wb_rf_wnum = ws_rf_waddr[4:0];
    end else begin : g_wnum_ext
        assign debug_wb_rf_wnum = {{(5 - RF_AW){1'b0}}, ws_rf_waddr};
    end

endmodule

// File: tb/tb_wb_stage_p.sv
// Bench for wb_stage_p. Two instances share one stimulus stream:
//   index 0: CSR_RD_LAT = 2, SQUASH_CYCLES = 4
//   index 1: CSR_RD_LAT = 0, SQUASH_CYCLES = 0
// A per-beat model predicts every output of both instances each cycle, and
// directed scenarios pin selected outputs to hand-computed literals.
module tb_wb_stage_p;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic [5:0]  exc;
        logic        ertn;
    } beat_t;

    typedef struct packed {
        logic        allowin;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        ex;
        logic        ertn;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        squash;
        logic [31:0] dpc;
        logic [3:0]  dwe;
        logic [4:0]  dwnum;
        logic [31:0] dwdata;
    } out_t;

    logic        clk = 1'b0;
    logic        reset;
    beat_t       in_b;
    logic [31:0] csr_rvalue;
    int          checks = 0;
    int          errors = 0;

    logic        w_allowin [2];
    logic        w_csr_re  [2];
    logic        w_csr_we  [2];
    logic [13:0] w_csr_num [2];
    logic [31:0] w_wmask   [2];
    logic [31:0] w_wvalue  [2];
    logic        w_ex      [2];
    logic        w_ertn    [2];
    logic [5:0]  w_ecode   [2];
    logic [8:0]  w_esub    [2];
    logic [31:0] w_pc      [2];
    logic [31:0] w_vaddr   [2];
    logic        w_rf_we   [2];
    logic [4:0]  w_waddr   [2];
    logic [31:0] w_wdata   [2];
    logic        w_squash  [2];
    logic [31:0] w_dpc     [2];
    logic [3:0]  w_dwe     [2];
    logic [4:0]  w_dwnum   [2];
    logic [31:0] w_dwdata  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_stage_p #(
            .DATA_W        (32),
            .RF_AW         (5),
            .CSR_RD_LAT    ((g == 0) ? 2 : 0),
            .SQUASH_CYCLES ((g == 0) ? 4 : 0)
        ) dut (
            .clk               (clk),
            .reset             (reset),
            .ms2ws_valid       (in_b.valid),
            .ws_allowin        (w_allowin[g]),
            .ms_pc             (in_b.pc),
            .ms_vaddr          (in_b.vaddr),
            .ms_rf_we          (in_b.rf_we),
            .ms_rf_waddr       (in_b.waddr),
            .ms_rf_wdata       (in_b.wdata),
            .ms_csr_re         (in_b.csr_re),
            .ms_csr_we         (in_b.csr_we),
            .ms_csr_num        (in_b.csr_num),
            .ms_csr_wmask      (in_b.wmask),
            .ms_csr_wvalue     (in_b.wvalue),
            .ms_exc            (in_b.exc),
            .ms_ertn           (in_b.ertn),
            .csr_rvalue        (csr_rvalue),
            .csr_re            (w_csr_re[g]),
            .csr_we            (w_csr_we[g]),
            .csr_num           (w_csr_num[g]),
            .csr_wmask         (w_wmask[g]),
            .csr_wvalue        (w_wvalue[g]),
            .ws_ex             (w_ex[g]),
            .ertn_flush        (w_ertn[g]),
            .ws_ecode          (w_ecode[g]),
            .ws_esubcode       (w_esub[g]),
            .ws_pc             (w_pc[g]),
            .ws_vaddr          (w_vaddr[g]),
            .ws_rf_we          (w_rf_we[g]),
            .ws_rf_waddr       (w_waddr[g]),
            .ws_rf_wdata       (w_wdata[g]),
            .ws_squash         (w_squash[g]),
            .debug_wb_pc       (w_dpc[g]),
            .debug_wb_rf_we    (w_dwe[g]),
            .debug_wb_rf_wnum  (w_dwnum[g]),
            .debug_wb_rf_wdata (w_dwdata[g])
        );
    end

    // ---------------- model ----------------
    int    LAT [2] = '{2, 0};
    int    SQ  [2] = '{4, 0};
    bit    held      [2];
    int    wait_left [2];
    int    drop_left [2];
    beat_t hb        [2];

    function automatic logic [5:0] prio(logic [5:0] e);
        // e = {ale, adef, ine, int, brk, sys}
        if (e[2]) return 6'h00;
        if (e[4]) return 6'h08;
        if (e[5]) return 6'h09;
        if (e[0]) return 6'h0B;
        if (e[1]) return 6'h0C;
        if (e[3]) return 6'h0D;
        return 6'h00;
    endfunction

    function automatic void step_model(int k);
        bit busy;
        bit acc;
        busy = held[k] && (wait_left[k] > 0);
        acc  = in_b.valid && !busy;
        if (busy) begin
            wait_left[k]--;
            return;
        end
        if (held[k]) begin
            if ((|hb[k].exc) || hb[k].ertn) drop_left[k] = SQ[k];
            held[k] = 1'b0;
        end
        if (acc) begin
            if (drop_left[k] > 0) begin
                drop_left[k]--;
            end else begin
                held[k]      = 1'b1;
                hb[k]        = in_b;
                wait_left[k] = in_b.csr_re ? LAT[k] : 0;
            end
        end
    endfunction

    function automatic out_t exp_out(int k);
        out_t  o;
        beat_t b;
        bit    any;
        o   = '0;
        b   = hb[k];
        any = |b.exc;
        o.allowin = !(held[k] && (wait_left[k] > 0));
        o.squash  = !held[k] && (drop_left[k] > 0);
        if (held[k]) begin
            o.csr_re  = b.csr_re;
            o.csr_num = b.csr_num;
            o.wmask   = b.wmask;
            o.wvalue  = b.wvalue;
            o.ecode   = prio(b.exc);
            o.pc      = b.pc;
            o.vaddr   = b.vaddr;
            o.waddr   = b.waddr;
            o.wdata   = b.csr_re ? csr_rvalue : b.wdata;
            o.dpc     = b.pc;
            o.dwnum   = b.waddr;
            o.dwdata  = o.wdata;
            if (wait_left[k] == 0) begin
                o.rf_we  = b.rf_we && !any && !b.ertn;
                o.csr_we = b.csr_we && !any;
                o.ex     = any;
                o.ertn   = b.ertn && !any;
            end
        end
        o.dwe = {4{o.rf_we}};
        return o;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                held[k]      = 1'b0;
                wait_left[k] = 0;
                drop_left[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) step_model(k);
        end
    end

    // ---------------- checking ----------------
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic out_t get_act(int k);
        out_t a;
        a = '{allowin: w_allowin[k], csr_re: w_csr_re[k], csr_we: w_csr_we[k],
              csr_num: w_csr_num[k], wmask: w_wmask[k], wvalue: w_wvalue[k],
              ex: w_ex[k], ertn: w_ertn[k], ecode: w_ecode[k], esub: w_esub[k],
              pc: w_pc[k], vaddr: w_vaddr[k], rf_we: w_rf_we[k], waddr: w_waddr[k],
              wdata: w_wdata[k], squash: w_squash[k], dpc: w_dpc[k], dwe: w_dwe[k],
              dwnum: w_dwnum[k], dwdata: w_dwdata[k]};
        return a;
    endfunction

    task automatic cmp(int k);
        out_t  a;
        out_t  e;
        string p;
        a = get_act(k);
        e = exp_out(k);
        p = (k == 0) ? "m0" : "m1";
        check({p, ".ws_allowin"},  a.allowin, e.allowin);
        check({p, ".csr_re"},      a.csr_re,  e.csr_re);
        check({p, ".csr_we"},      a.csr_we,  e.csr_we);
        check({p, ".csr_num"},     a.csr_num, e.csr_num);
        check({p, ".csr_wmask"},   a.wmask,   e.wmask);
        check({p, ".csr_wvalue"},  a.wvalue,  e.wvalue);
        check({p, ".ws_ex"},       a.ex,      e.ex);
        check({p, ".ertn_flush"},  a.ertn,    e.ertn);
        check({p, ".ws_ecode"},    a.ecode,   e.ecode);
        check({p, ".ws_esubcode"}, a.esub,    e.esub);
        check({p, ".ws_pc"},       a.pc,      e.pc);
        check({p, ".ws_vaddr"},    a.vaddr,   e.vaddr);
        check({p, ".ws_rf_we"},    a.rf_we,   e.rf_we);
        check({p, ".ws_rf_waddr"}, a.waddr,   e.waddr);
        check({p, ".ws_rf_wdata"}, a.wdata,   e.wdata);
        check({p, ".ws_squash"},   a.squash,  e.squash);
        check({p, ".dbg_pc"},      a.dpc,     e.dpc);
        check({p, ".dbg_we"},      a.dwe,     e.dwe);
        check({p, ".dbg_wnum"},    a.dwnum,   e.dwnum);
        check({p, ".dbg_wdata"},   a.dwdata,  e.dwdata);
    endtask

    always @(negedge clk) begin
        cmp(0);
        cmp(1);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk(logic [31:0] pc, logic [4:0] wa, logic [31:0] wd);
        beat_t b;
        b         = '0;
        b.valid   = 1'b1;
        b.pc      = pc;
        b.vaddr   = pc ^ 32'hFFFF_0000;
        b.rf_we   = 1'b1;
        b.waddr   = wa;
        b.wdata   = wd;
        b.csr_num = 14'h0040 + 14'(wa);
        b.wmask   = 32'hFF00_FF00;
        b.wvalue  = wd + 32'd1;
        return b;
    endfunction

    logic [5:0] px_exc  [6] = '{6'b100100, 6'b110000, 6'b001000, 6'b100010, 6'b000001, 6'b000000};
    logic       px_ertn [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [5:0] px_code [6] = '{6'h00, 6'h08, 6'h0D, 6'h09, 6'h0B, 6'h00};

    initial begin
        beat_t b;
        in_b       = '0;
        csr_rvalue = 32'h5555_0000;
        reset      = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.allowin", w_allowin[0], 1);
        check("rst.rf_we",   w_rf_we[0],   0);
        check("rst.squash",  w_squash[0],  0);
        check("rst.dbg_pc",  w_dpc[1],     0);
        reset = 1'b0;
        tick();

        // Plain write
        in_b = mk(32'h1000_0000, 5'd5, 32'h1234);
        tick();
        in_b.valid = 1'b0;
        @(negedge clk);
        check("wr.rf_we",    w_rf_we[0], 1);
        check("wr.dbg_we",   w_dwe[0],   4'hF);
        check("wr.dbg_wnum", w_dwnum[0], 5);
        check("wr.dbg_wdat", w_dwdata[0], 32'h1234);
        tick();

        // CSR read, latency 2 on instance 0
        csr_rvalue = 32'hABCD;
        b = mk(32'h2000_0000, 5'd6, 32'h1111);
        b.csr_re = 1'b1;
        in_b = b;
        tick();
        in_b.valid = 1'b0;
        @(negedge clk);
        check("csr.allowin1", w_allowin[0], 0);
        tick();
        @(negedge clk);
        check("csr.allowin2", w_allowin[0], 0);
        check("csr.rf_we_h",  w_rf_we[0],   0);
        tick();
        @(negedge clk);
        check("csr.rf_we",   w_rf_we[0], 1);
        check("csr.wdata",   w_wdata[0], 32'hABCD);
        check("csr.allowin", w_allowin[0], 1);
        tick();
        @(negedge clk);
        check("csr.once", w_rf_we[0], 0);
        csr_rvalue = 32'h5555_0000;

        // Exception sys+brk, then 5 back-to-back beats
        b = mk(32'h3000_0000, 5'd7, 32'h77);
        b.exc = 6'b000011;
        in_b = b;
        tick();
        for (int i = 1; i <= 5; i++) begin
            in_b = mk(32'h3000_0000 + 32'(4 * i), 5'd8, 32'(i));
            @(negedge clk);
            if (i == 1) begin
                check("exc.ws_ex",  w_ex[0],    1);
                check("exc.ecode",  w_ecode[0], 6'h0B);
                check("exc.rf_we",  w_rf_we[0], 0);
            end else begin
                check($sformatf("exc.drop%0d.rf_we", i), w_rf_we[0], 0);
                check($sformatf("exc.drop%0d.ex", i),    w_ex[0],    0);
                check($sformatf("exc.sq%0d", i), w_squash[0], (i == 5) ? 0 : 1);
            end
            tick();
        end
        in_b.valid = 1'b0;
        @(negedge clk);
        check("exc.b5.rf_we", w_rf_we[0], 1);
        check("exc.b5.pc",    w_pc[0],    32'h3000_0014);
        tick();

        // ERTN on instance 1 (no squash), then reset during instance 0 squash
        b = mk(32'h4000_0000, 5'd9, 32'h99);
        b.ertn = 1'b1;
        in_b = b;
        tick();
        in_b = mk(32'h4100_0000, 5'd10, 32'hF0);
        @(negedge clk);
        check("ertn.flush", w_ertn[1],  1);
        check("ertn.rf_we", w_rf_we[1], 0);
        tick();
        in_b = mk(32'h4200_0000, 5'd11, 32'hF1);
        @(negedge clk);
        check("ertn.once",  w_ertn[1],  0);
        check("ertn.next",  w_rf_we[1], 1);
        check("ertn.pc",    w_pc[1],    32'h4100_0000);
        tick();
        in_b.valid = 1'b0;
        @(negedge clk);
        check("rsq.squash", w_squash[0], 1);
        #2 reset = 1'b1;
        #1;
        check("rsq.squash0", w_squash[0],  0);
        check("rsq.allowin", w_allowin[0], 1);
        check("rsq.rf_we1",  w_rf_we[1],   0);
        check("rsq.pc1",     w_pc[1],      0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        in_b = mk(32'h5000_0000, 5'd12, 32'h55);
        tick();
        in_b.valid = 1'b0;
        @(negedge clk);
        check("rsq.first.rf_we", w_rf_we[0], 1);
        check("rsq.first.pc",    w_pc[0],    32'h5000_0000);
        tick();

        // Back-to-back 8 writes
        in_b = mk(32'h6000_0000, 5'd1, 32'h100);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i < 7) in_b = mk(32'h6000_0000 + 32'(4 * (i + 1)), 5'(i + 2), 32'h100 + 32'(i + 1));
            else in_b.valid = 1'b0;
            @(negedge clk);
            check($sformatf("b2b%0d.rf_we", i), w_rf_we[0], 1);
            check($sformatf("b2b%0d.pc", i),    w_pc[0],    32'h6000_0000 + 32'(4 * i));
            tick();
        end

        // Priority sweep on instance 1, with csr_we on every beat
        for (int i = 0; i < 6; i++) begin
            b = mk(32'h7000_0000 + 32'(4 * i), 5'd3, 32'(i));
            b.exc    = px_exc[i];
            b.ertn   = px_ertn[i];
            b.csr_we = 1'b1;
            in_b = b;
            tick();
            in_b.valid = 1'b0;
            @(negedge clk);
            check($sformatf("prio%0d.ecode", i),  w_ecode[1], px_code[i]);
            check($sformatf("prio%0d.ex", i),     w_ex[1],    (px_exc[i] != 0) ? 1 : 0);
            check($sformatf("prio%0d.ertn", i),   w_ertn[1],  0);
            check($sformatf("prio%0d.csr_we", i), w_csr_we[1], (px_exc[i] != 0) ? 0 : 1);
            tick();
        end

        repeat (6) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
